// File: rtl/game_ctrl_if.sv
// game_ctrl_if: bundles the VGA counters, the start button and the attacker
// game-over flags going into game_ctrl, together with the play controls and
// status it drives back out.
//   slave  : used by game_ctrl (counters/start/atk_over in, controls/status out)
//   master : used by whatever drives game_ctrl (the opposite directions)
// Signals:
//   H_count, V_count [16:0]  VGA pixel/line counters
//   game_start               debounced start button level
//   atk_over [NUM_ATTK-1:0]  per-attacker game-over flags, bit 0 = attacker 1
//   game_stop, game_on, game_over  registered play controls
//   lives [2:0], score [13:0], state_dbg [1:0]  status
interface game_ctrl_if #(
    parameter int NUM_ATTK = 6
);
    logic [16:0]         H_count;
    logic [16:0]         V_count;
    logic                game_start;
    logic [NUM_ATTK-1:0] atk_over;
    logic                game_stop;
    logic                game_on;
    logic                game_over;
    logic [2:0]          lives;
    logic [13:0]         score;
    logic [1:0]          state_dbg;

    modport master (
        output H_count, V_count, game_start, atk_over,
        input  game_stop, game_on, game_over, lives, score, state_dbg
    );

    modport slave (
        input  H_count, V_count, game_start, atk_over,
        output game_stop, game_on, game_over, lives, score, state_dbg
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer sitting after the attacker blocks. Makes one
// decision per video frame (at H_count==0 && V_count==0): counts survival
// frames into a saturating score, takes one life per frame in which any
// attacker reports game over, freezes play for HIT_FRAMES frames after a hit
// and ends the game when the last life is gone.
// Ports:
//   clk_65M  65 MHz pixel/system clock
//   clear    asynchronous active-high reset
//   bus      game_ctrl_if slave port (counters, start, atk_over in;
//            game_stop, game_on, game_over, lives, score, state_dbg out)
//
// state | meaning
// IDLE  | power-up, waiting for a start press, attackers held
// PLAY  | game running, scoring survival frames
// HIT   | attackers held for HIT_FRAMES frames after losing a life
// OVER  | no lives left, lives/score held for display until a new start
module game_ctrl #(
    parameter int NUM_ATTK     = 6,
    parameter int LIVES_INIT   = 3,
    parameter int HIT_FRAMES   = 60,
    parameter int SCORE_FRAMES = 30,
    parameter int SCORE_MAX    = 9999
) (
    input  logic        clk_65M,
    input  logic        clear,
    game_ctrl_if.slave  bus
);
    localparam int SURV_W = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
    localparam int FRZ_W  = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

    localparam logic [SURV_W-1:0] SURV_LAST  = SURV_W'(SCORE_FRAMES - 1);
    localparam logic [FRZ_W-1:0]  FRZ_LAST   = FRZ_W'(HIT_FRAMES - 1);
    localparam logic [2:0]        LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [13:0]       SCORE_TOP  = 14'(SCORE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t            state;
    logic              start_q;
    logic [SURV_W-1:0] surv_cnt;
    logic [FRZ_W-1:0]  frz_cnt;
    logic [2:0]        lives_r;
    logic [13:0]       score_r;
    logic              stop_r;
    logic              on_r;
    logic              over_r;

    logic frame_tick;
    logic start_edge;

    assign frame_tick = (bus.V_count == 17'd0) && (bus.H_count == 17'd0);
    assign start_edge = bus.game_start & ~start_q;

    // Outputs are assigned alongside each state change so they always match
    // the state being entered.
    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            stop_r   <= 1'b1;
            on_r     <= 1'b0;
            over_r   <= 1'b0;
            lives_r  <= LIVES_LOAD;
            score_r  <= '0;
            surv_cnt <= '0;
            frz_cnt  <= '0;
            start_q  <= 1'b0;
        end else begin
            start_q <= bus.game_start;
            unique case (state)
                IDLE, OVER: begin
                    if (start_edge) begin
                        state    <= PLAY;
                        stop_r   <= 1'b0;
                        on_r     <= 1'b1;
                        over_r   <= 1'b0;
                        lives_r  <= LIVES_LOAD;
                        score_r  <= '0;
                        surv_cnt <= '0;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        // Any number of simultaneous flags costs one life.
                        if (|bus.atk_over) begin
                            state   <= HIT;
                            stop_r  <= 1'b1;
                            on_r    <= 1'b0;
                            lives_r <= lives_r - 3'd1;
                            frz_cnt <= '0;
                        end else if (surv_cnt == SURV_LAST) begin
                            surv_cnt <= '0;
                            if (score_r < SCORE_TOP) begin
                                score_r <= score_r + 14'd1;
                            end
                        end else begin
                            surv_cnt <= surv_cnt + 1'b1;
                        end
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        if (frz_cnt == FRZ_LAST) begin
                            if (lives_r == 3'd0) begin
                                state  <= OVER;
                                over_r <= 1'b1;
                            end else begin
                                state    <= PLAY;
                                stop_r   <= 1'b0;
                                on_r     <= 1'b1;
                                surv_cnt <= '0;
                            end
                        end else begin
                            frz_cnt <= frz_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.game_stop = stop_r;
    assign bus.game_on   = on_r;
    assign bus.game_over = over_r;
    assign bus.lives     = lives_r;
    assign bus.score     = score_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: drives two game_ctrl instances (default parameters and a
// shrunken variant where score saturation is reachable) from one frame
// generator, and compares every output every clock against a frame-level
// model of the game rules. Directed scenarios are followed by random play.
module tb_game_ctrl;
    localparam int H_LEN = 4;
    localparam int V_LEN = 2;
    localparam int FRAME = H_LEN * V_LEN;

    localparam int LI[2] = '{3, 2};
    localparam int HF[2] = '{60, 3};
    localparam int SF[2] = '{30, 2};
    localparam int SM[2] = '{9999, 5};

    logic clk_65M = 1'b0;
    logic clear   = 1'b1;
    int   h = 0;
    int   v = 0;
    logic start = 1'b0;
    logic [5:0] atk = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_65M = ~clk_65M;

    game_ctrl_if #(.NUM_ATTK(6)) if0 ();
    game_ctrl_if #(.NUM_ATTK(6)) if1 ();

    assign if0.H_count    = 17'(h);
    assign if0.V_count    = 17'(v);
    assign if0.game_start = start;
    assign if0.atk_over   = atk;
    assign if1.H_count    = 17'(h);
    assign if1.V_count    = 17'(v);
    assign if1.game_start = start;
    assign if1.atk_over   = atk;

    game_ctrl u_dut (
        .clk_65M (clk_65M),
        .clear   (clear),
        .bus     (if0)
    );

    game_ctrl #(
        .NUM_ATTK     (6),
        .LIVES_INIT   (2),
        .HIT_FRAMES   (3),
        .SCORE_FRAMES (2),
        .SCORE_MAX    (5)
    ) u_sml (
        .clk_65M (clk_65M),
        .clear   (clear),
        .bus     (if1)
    );

    // Model: st 0=IDLE 1=PLAY 2=HIT 3=OVER; survived = frames survived since
    // the last credit; frozen = frames spent in the current freeze.
    typedef struct {
        int st;
        int lives;
        int score;
        int survived;
        int frozen;
        bit btn_prev;
    } mdl_t;

    mdl_t m[2];

    function automatic mdl_t m_reset(int k);
        mdl_t r;
        r.st = 0; r.lives = LI[k]; r.score = 0;
        r.survived = 0; r.frozen = 0; r.btn_prev = 1'b0;
        return r;
    endfunction

    function automatic mdl_t m_step(mdl_t r, int k, bit tick, bit btn, int flags);
        bit pressed;
        pressed    = btn && !r.btn_prev;
        r.btn_prev = btn;
        if (r.st == 0 || r.st == 3) begin
            if (pressed) begin
                r.st = 1; r.lives = LI[k]; r.score = 0; r.survived = 0;
            end
        end else if (r.st == 1) begin
            if (tick) begin
                if (flags != 0) begin
                    r.st = 2; r.lives = r.lives - 1; r.frozen = 0;
                end else begin
                    r.survived++;
                    if (r.survived == SF[k]) begin
                        r.survived = 0;
                        r.score = (r.score + 1 > SM[k]) ? SM[k] : r.score + 1;
                    end
                end
            end
        end else begin
            if (tick) begin
                r.frozen++;
                if (r.frozen == HF[k]) begin
                    if (r.lives == 0) r.st = 3;
                    else begin
                        r.st = 1; r.survived = 0;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic cmp_inst(input string nm, input mdl_t r, input int st, input int stp,
                            input int on, input int ovr, input int lv, input int sc);
        chk({nm, ".state"}, st, r.st);
        chk({nm, ".game_stop"}, stp, (r.st != 1) ? 1 : 0);
        chk({nm, ".game_on"}, on, (r.st == 1) ? 1 : 0);
        chk({nm, ".game_over"}, ovr, (r.st == 3) ? 1 : 0);
        chk({nm, ".lives"}, lv, r.lives);
        chk({nm, ".score"}, sc, r.score);
    endtask

    task automatic cmp_both();
        cmp_inst("dflt", m[0], int'(if0.state_dbg), int'(if0.game_stop), int'(if0.game_on),
                 int'(if0.game_over), int'(if0.lives), int'(if0.score));
        cmp_inst("sml", m[1], int'(if1.state_dbg), int'(if1.game_stop), int'(if1.game_on),
                 int'(if1.game_over), int'(if1.lives), int'(if1.score));
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later,
    // then the frame counters advance.
    task automatic cycle();
        bit tick;
        @(posedge clk_65M);
        tick = (h == 0 && v == 0);
        for (int k = 0; k < 2; k++) begin
            if (clear) m[k] = m_reset(k);
            else       m[k] = m_step(m[k], k, tick, start, int'(atk));
        end
        #1;
        cmp_both();
        h++;
        if (h == H_LEN) begin
            h = 0;
            v = (v + 1) % V_LEN;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_clear();
        #2;
        clear = 1'b1;
        m[0] = m_reset(0);
        m[1] = m_reset(1);
        #1;
        cmp_both();
        run(2);
        clear = 1'b0;
    endtask

    // Advance until the next clock edge samples a frame tick.
    task automatic align();
        int guard;
        guard = 0;
        while (!(h == 0 && v == 0) && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        if (!(h == 0 && v == 0)) chk("align_timeout", guard, 0);
    endtask

    task automatic hit(input logic [5:0] flags);
        align();
        atk = flags;
        cycle();
        atk = '0;
    endtask

    initial begin
        m[0] = m_reset(0);
        m[1] = m_reset(1);
        run(3);
        clear = 1'b0;

        // 1: clear mid-frame, then three idle frames
        run(5);
        pulse_clear();
        run(3 * FRAME);
        chk("s1.state", int'(if0.state_dbg), 0);
        chk("s1.game_stop", int'(if0.game_stop), 1);
        chk("s1.lives", int'(if0.lives), 3);
        chk("s1.score", int'(if0.score), 0);

        // 2: start press, 90 clean frames
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("s2.state", int'(if0.state_dbg), 1);
        chk("s2.game_stop", int'(if0.game_stop), 0);
        chk("s2.game_on", int'(if0.game_on), 1);
        run(90 * FRAME);
        chk("s2.score", int'(if0.score), 3);
        chk("s5.sml_sat", int'(if1.score), 5);

        // 3: two flags in one frame cost one life; 60-frame freeze
        hit(6'b100001);
        chk("s3.lives", int'(if0.lives), 2);
        chk("s3.state", int'(if0.state_dbg), 2);
        chk("s3.game_stop", int'(if0.game_stop), 1);
        run(59 * FRAME);
        chk("s3.still_hit", int'(if0.state_dbg), 2);
        chk("s3.stop_held", int'(if0.game_stop), 1);
        run(FRAME);
        chk("s3.resume", int'(if0.state_dbg), 1);
        chk("s3.score", int'(if0.score), 3);
        chk("s5.sml_hold", int'(if1.score), 5);

        // 4: two more hits -> OVER, held start does not restart
        hit(6'b000100);
        run(60 * FRAME);
        chk("s4.lives1", int'(if0.lives), 1);
        hit(6'b010000);
        run(59 * FRAME);
        start = 1'b1;
        run(FRAME);
        chk("s4.state", int'(if0.state_dbg), 3);
        chk("s4.game_over", int'(if0.game_over), 1);
        chk("s4.lives", int'(if0.lives), 0);
        run(3 * FRAME);
        chk("s4.held", int'(if0.state_dbg), 3);
        start = 1'b0;
        run(4);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("s4.restart", int'(if0.state_dbg), 1);
        chk("s4.reload", int'(if0.lives), 3);
        chk("s4.score0", int'(if0.score), 0);

        // 6: clear in the middle of a freeze
        hit(6'b000010);
        run(20 * FRAME);
        chk("s6.in_hit", int'(if0.state_dbg), 2);
        pulse_clear();
        chk("s6.state", int'(if0.state_dbg), 0);
        chk("s6.game_stop", int'(if0.game_stop), 1);
        chk("s6.lives", int'(if0.lives), 3);
        chk("s6.score", int'(if0.score), 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("s6.start", int'(if0.state_dbg), 1);
        run(90 * FRAME);
        chk("s6.score3", int'(if0.score), 3);

        // random play
        for (int i = 0; i < 3200; i++) begin
            atk = ($urandom_range(0, 99) < 4) ? 6'($urandom_range(1, 63)) : 6'd0;
            if ($urandom_range(0, 99) < 2) start = ~start;
            if ($urandom_range(0, 1999) == 0) pulse_clear();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
